// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment digit scanner with a double-buffered (shadow/active) frame register.
// Optional feature macro: SEG_SCAN_LZB_EN enables leading-zero blanking when a frame is committed.
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int NUM_DIG  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    input  logic [4*NUM_DIG-1:0]   load_data,
    output logic                   load_ready,
    output logic [3:0]             bcd_out,
    output logic [NUM_DIG-1:0]     dig_sel,
    output logic                   frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [CW-1:0]      DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]      IDX_LAST = IW'(NUM_DIG - 1);
    localparam logic [NUM_DIG-1:0] SEL_ONE  = NUM_DIG'(1);

    typedef enum logic {
        BLANK,
        SCAN
    } state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic                  tick;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_next;
    logic                  pending;
    logic [4*NUM_DIG-1:0]  shadow;
    logic [4*NUM_DIG-1:0]  active;
    logic [4*NUM_DIG-1:0]  copy_data;
    logic [4*NUM_DIG-1:0]  next_active;
    logic                  accept;
    logic                  boundary;
    logic                  commit;
`ifdef SEG_SCAN_LZB_EN
    logic                  lead;
`endif

    assign tick       = (count == DIV_LAST);
    assign load_ready = !pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // The first SCAN slot after leaving BLANK is always digit 0.
    always_comb begin
        accept      = load_valid && !pending;
        boundary    = tick && ((state == SCAN && idx == IDX_LAST) || (state == BLANK && pending));
        commit      = boundary && pending;
        idx_next    = (state == BLANK || idx == IDX_LAST) ? '0 : idx + IW'(1);
        next_active = commit ? copy_data : active;
    end

    always_comb begin
        copy_data = shadow;
`ifdef SEG_SCAN_LZB_EN
        // Digit 0 is excluded so an all-zero value still shows a single 0.
        lead = 1'b1;
        for (int k = NUM_DIG - 1; k >= 1; k--) begin
            if (lead && shadow[4*k +: 4] == 4'h0) begin
                copy_data[4*k +: 4] = 4'hF;
            end
            lead = lead && (shadow[4*k +: 4] == 4'h0 || shadow[4*k +: 4] == 4'hF);
        end
`endif
    end

    // A load accepted on a boundary cycle had pending clear, so it is held for the next boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BLANK;
            idx        <= '0;
            pending    <= 1'b0;
            shadow     <= '1;
            active     <= '1;
            dig_sel    <= '0;
            bcd_out    <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (accept) begin
                shadow  <= load_data;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            if (commit) begin
                active <= copy_data;
            end
            if (tick && (state == SCAN || pending)) begin
                state   <= SCAN;
                idx     <= idx_next;
                dig_sel <= SEL_ONE << idx_next;
                bcd_out <= next_active[{idx_next, 2'b00} +: 4];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl (SCAN_DIV=4, NUM_DIG=4).
// Positions in comments count clk rising edges since reset release; sampling is on falling edges.
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [3:0]  bcd_out;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int checks;
    int passed;

`ifdef SEG_SCAN_LZB_EN
    localparam logic [3:0] LZ = 4'hF;
`else
    localparam logic [3:0] LZ = 4'h0;
`endif

    seg_scan_ctrl #(
        .SCAN_DIV(4),
        .NUM_DIG (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .bcd_out   (bcd_out),
        .dig_sel   (dig_sel),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic advance(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench on a falling edge right after release (position 0).
    task automatic do_reset();
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        advance(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int pulses;
        int bad_sel;
        int bad_bcd;
        int bad_rdy;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        advance(1);
        checks++; if (dig_sel !== 4'b0000) $display("[TB] FAIL reset_sel: got %b expected 0000", dig_sel); else passed++;
        checks++; if (bcd_out !== 4'hF) $display("[TB] FAIL reset_bcd: got %h expected f", bcd_out); else passed++;
        checks++; if (load_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", load_ready); else passed++;
        checks++; if (frame_done !== 1'b0) $display("[TB] FAIL reset_fd: got %b expected 0", frame_done); else passed++;
        advance(1);
        rst = 1'b0;
        pulses = 0; bad_sel = 0; bad_bcd = 0; bad_rdy = 0;
        for (int i = 0; i < 100; i++) begin
            advance(1);
            if (frame_done !== 1'b0) pulses++;
            if (dig_sel !== 4'b0000) bad_sel++;
            if (bcd_out !== 4'hF) bad_bcd++;
            if (load_ready !== 1'b1) bad_rdy++;
        end
        checks++; if (pulses != 0) $display("[TB] FAIL idle_fd_pulses: got %0d expected 0", pulses); else passed++;
        checks++; if (bad_sel != 0) $display("[TB] FAIL idle_sel_cycles: got %0d expected 0", bad_sel); else passed++;
        checks++; if (bad_bcd != 0) $display("[TB] FAIL idle_bcd_cycles: got %0d expected 0", bad_bcd); else passed++;
        checks++; if (bad_rdy != 0) $display("[TB] FAIL idle_ready_cycles: got %0d expected 0", bad_rdy); else passed++;
    endtask

    // Ends at position 20, in SCAN on digit 0 showing 16'h1234.
    task automatic test_scan();
        logic [3:0] exp_sel [5];
        logic [3:0] exp_bcd [5];
        logic       exp_fd  [5];
        exp_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_bcd = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h4};
        exp_fd  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        load_valid = 1'b1;
        load_data  = 16'h1234;
        advance(1);
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) $display("[TB] FAIL scan_ready_after_load: got %b expected 0", load_ready); else passed++;
        checks++; if (dig_sel !== 4'b0000) $display("[TB] FAIL scan_still_blank: got %b expected 0000", dig_sel); else passed++;
        advance(3);
        for (int i = 0; i < 5; i++) begin
            checks++; if (dig_sel !== exp_sel[i]) $display("[TB] FAIL scan_sel[%0d]: got %b expected %b", i, dig_sel, exp_sel[i]); else passed++;
            checks++; if (bcd_out !== exp_bcd[i]) $display("[TB] FAIL scan_bcd[%0d]: got %h expected %h", i, bcd_out, exp_bcd[i]); else passed++;
            checks++; if (frame_done !== exp_fd[i]) $display("[TB] FAIL scan_fd[%0d]: got %b expected %b", i, frame_done, exp_fd[i]); else passed++;
            if (i == 0) begin
                checks++; if (load_ready !== 1'b1) $display("[TB] FAIL scan_ready_after_commit: got %b expected 1", load_ready); else passed++;
                advance(1);
                checks++; if (frame_done !== 1'b0) $display("[TB] FAIL scan_fd_one_cycle: got %b expected 0", frame_done); else passed++;
                advance(3);
            end else if (i < 4) begin
                advance(4);
            end
        end
    endtask

    // Starts at position 20; ends at position 52 on digit 0 showing 16'h5678.
    task automatic test_back_pressure();
        logic [3:0] exp_sel [4];
        logic [3:0] exp_bcd [4];
        exp_sel = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_bcd = '{4'h7, 4'h6, 4'h5, 4'h8};
        load_valid = 1'b1;
        load_data  = 16'h5678;
        advance(1);
        load_data = 16'h9999;
        checks++; if (load_ready !== 1'b0) $display("[TB] FAIL bp_ready_busy: got %b expected 0", load_ready); else passed++;
        advance(11);
        checks++; if (bcd_out !== 4'h1) $display("[TB] FAIL bp_old_frame_bcd: got %h expected 1", bcd_out); else passed++;
        advance(3);
        checks++; if (load_ready !== 1'b0) $display("[TB] FAIL bp_ready_before_boundary: got %b expected 0", load_ready); else passed++;
        advance(1);
        load_valid = 1'b0;
        checks++; if (dig_sel !== 4'b0001) $display("[TB] FAIL bp_new_sel: got %b expected 0001", dig_sel); else passed++;
        checks++; if (bcd_out !== 4'h8) $display("[TB] FAIL bp_new_bcd: got %h expected 8", bcd_out); else passed++;
        checks++; if (frame_done !== 1'b1) $display("[TB] FAIL bp_fd: got %b expected 1", frame_done); else passed++;
        checks++; if (load_ready !== 1'b1) $display("[TB] FAIL bp_ready_after_boundary: got %b expected 1", load_ready); else passed++;
        for (int i = 0; i < 4; i++) begin
            advance(4);
            checks++; if (dig_sel !== exp_sel[i]) $display("[TB] FAIL bp_sel[%0d]: got %b expected %b", i, dig_sel, exp_sel[i]); else passed++;
            checks++; if (bcd_out !== exp_bcd[i]) $display("[TB] FAIL bp_bcd[%0d]: got %h expected %h", i, bcd_out, exp_bcd[i]); else passed++;
        end
        checks++; if (load_ready !== 1'b1) $display("[TB] FAIL bp_9999_rejected_ready: got %b expected 1", load_ready); else passed++;
    endtask

    // Starts at position 52; load lands exactly on the boundary at edge 68.
    task automatic test_boundary_load();
        logic [3:0] exp_bcd [4];
        exp_bcd = '{4'hE, 4'hA, 4'h0, 4'hB};
        advance(15);
        load_valid = 1'b1;
        load_data  = 16'hB0AE;
        advance(1);
        load_valid = 1'b0;
        checks++; if (bcd_out !== 4'h8) $display("[TB] FAIL bnd_old_bcd: got %h expected 8", bcd_out); else passed++;
        checks++; if (frame_done !== 1'b1) $display("[TB] FAIL bnd_fd: got %b expected 1", frame_done); else passed++;
        checks++; if (load_ready !== 1'b0) $display("[TB] FAIL bnd_ready_pending: got %b expected 0", load_ready); else passed++;
        advance(4);
        checks++; if (bcd_out !== 4'h7) $display("[TB] FAIL bnd_old_frame_bcd: got %h expected 7", bcd_out); else passed++;
        advance(11);
        checks++; if (load_ready !== 1'b0) $display("[TB] FAIL bnd_ready_before: got %b expected 0", load_ready); else passed++;
        advance(1);
        checks++; if (frame_done !== 1'b1) $display("[TB] FAIL bnd_fd2: got %b expected 1", frame_done); else passed++;
        checks++; if (load_ready !== 1'b1) $display("[TB] FAIL bnd_ready_after: got %b expected 1", load_ready); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bcd_out !== exp_bcd[i]) $display("[TB] FAIL bnd_new_bcd[%0d]: got %h expected %h", i, bcd_out, exp_bcd[i]); else passed++;
            advance(4);
        end
    endtask

    task automatic test_lzb();
        logic [3:0] exp_a [4];
        logic [3:0] exp_b [4];
        logic [3:0] exp_sel [4];
        exp_a   = '{4'h0, 4'h5, LZ, LZ};
        exp_b   = '{4'h0, LZ, LZ, LZ};
        exp_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        load_valid = 1'b1;
        load_data  = 16'h0050;
        advance(1);
        load_valid = 1'b0;
        advance(3);
        for (int i = 0; i < 4; i++) begin
            checks++; if (dig_sel !== exp_sel[i]) $display("[TB] FAIL lzb_sel[%0d]: got %b expected %b", i, dig_sel, exp_sel[i]); else passed++;
            checks++; if (bcd_out !== exp_a[i]) $display("[TB] FAIL lzb_0050[%0d]: got %h expected %h", i, bcd_out, exp_a[i]); else passed++;
            advance(4);
        end
        load_valid = 1'b1;
        load_data  = 16'h0000;
        advance(1);
        load_valid = 1'b0;
        advance(15);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bcd_out !== exp_b[i]) $display("[TB] FAIL lzb_0000[%0d]: got %h expected %h", i, bcd_out, exp_b[i]); else passed++;
            advance(4);
        end
    endtask

    task automatic test_reset_mid_frame();
        int lit;
        do_reset();
        load_valid = 1'b1;
        load_data  = 16'h1234;
        advance(1);
        load_valid = 1'b0;
        advance(11);
        checks++; if (dig_sel !== 4'b0100) $display("[TB] FAIL rmf_idx2_sel: got %b expected 0100", dig_sel); else passed++;
        load_valid = 1'b1;
        load_data  = 16'h5678;
        advance(1);
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) $display("[TB] FAIL rmf_pending: got %b expected 0", load_ready); else passed++;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (dig_sel !== 4'b0000) $display("[TB] FAIL rmf_async_sel: got %b expected 0000", dig_sel); else passed++;
        checks++; if (bcd_out !== 4'hF) $display("[TB] FAIL rmf_async_bcd: got %h expected f", bcd_out); else passed++;
        checks++; if (load_ready !== 1'b1) $display("[TB] FAIL rmf_async_ready: got %b expected 1", load_ready); else passed++;
        advance(2);
        rst = 1'b0;
        lit = 0;
        for (int i = 0; i < 40; i++) begin
            advance(1);
            if (dig_sel !== 4'b0000 || bcd_out !== 4'hF || frame_done !== 1'b0) lit++;
        end
        checks++; if (lit != 0) $display("[TB] FAIL rmf_stays_blank: got %0d active cycles expected 0", lit); else passed++;
    endtask

    initial begin
        checks     = 0;
        passed     = 0;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        test_reset();
        test_scan();
        test_back_pressure();
        test_boundary_load();
        test_lzb();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
